// File: rtl/spike_if_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_if_encoder_if                                                  |
// | Current-in / spike-out handshake bundle for spike_if_encoder.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface spike_if_encoder_if #(
  parameter int N         = 8,
  parameter int IN_WIDTH  = 11,
  parameter int POT_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [N-1:0][IN_WIDTH-1:0]   currents;
  logic [POT_WIDTH-1:0]         threshold;
  logic [3:0]                   leak_shift;
  logic                         clr;
  logic                         out_valid;
  logic                         out_ready;
  logic [N-1:0]                 spikes_out;

  modport master (
    output in_valid, currents, threshold, leak_shift, clr, out_ready,
    input  in_ready, out_valid, spikes_out
  );

  modport slave (
    input  in_valid, currents, threshold, leak_shift, clr, out_ready,
    output in_ready, out_valid, spikes_out
  );
endinterface
`default_nettype wire

// File: rtl/spike_if_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_if_encoder                                                     |
// | Layer of N leaky integrate-and-fire neurons, one timestep per accept.|
// | Optional refractory counters: define SPIKE_REFRAC_EN.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spike_if_encoder #(
  parameter int N         = 8,
  parameter int IN_WIDTH  = 11,
  parameter int POT_WIDTH = 16,
  parameter int REFRAC    = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  spike_if_encoder_if.slave bus
);

  localparam int c_SUM_W = POT_WIDTH + 1;
`ifdef SPIKE_REFRAC_EN
  localparam logic [3:0] c_REFRAC = 4'(REFRAC);
`endif

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_out_valid;
  logic         w_in_ready;
  logic         w_accept;
  logic [N-1:0] w_spike;
  logic [N-1:0] r_spikes;

  assign w_out_valid = (r_state == S_FULL);
  assign w_in_ready  = !bus.clr && (!w_out_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_neuron
    logic [POT_WIDTH-1:0] r_v;
    logic [POT_WIDTH-1:0] w_leak;
    logic [POT_WIDTH-1:0] w_vnext;
    logic [POT_WIDTH:0]   w_sum;
    logic                 w_refr;
    logic                 w_fire;

    // v - (v >> s) never underflows, so only the add can overflow
    assign w_leak  = (bus.leak_shift == 4'd0) ? '0 : (r_v >> bus.leak_shift);
    assign w_sum   = {1'b0, r_v - w_leak} + c_SUM_W'(bus.currents[gi]);
    assign w_vnext = w_sum[POT_WIDTH] ? '1 : w_sum[POT_WIDTH-1:0];

`ifdef SPIKE_REFRAC_EN
    logic [3:0] r_cnt;
    assign w_refr = (r_cnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (bus.clr) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_refr) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (w_fire) begin
          r_cnt <= c_REFRAC;
        end
      end
    end
`else
    assign w_refr = 1'b0;
`endif

    assign w_fire       = !w_refr && (w_vnext >= bus.threshold);
    assign w_spike[gi]  = w_fire;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= '0;
      end else if (bus.clr) begin
        r_v <= '0;
      end else if (w_accept) begin
        r_v <= (w_refr || w_fire) ? '0 : w_vnext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_accept) begin
          w_state_nxt = S_FULL;
        end else if (bus.out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spikes <= '0;
    end else if (w_accept) begin
      r_spikes <= w_spike;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.spikes_out = r_spikes;

endmodule
`default_nettype wire

// File: tb/tb_spike_if_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spike_if_encoder                                                  |
// | Directed table, corner sequences and random traffic vs LIF model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spike_if_encoder;

  localparam int N      = 8;
  localparam int IW     = 11;
  localparam int PW     = 16;
  localparam int REFRAC = 2;
  localparam int VMAX   = (1 << PW) - 1;
`ifdef SPIKE_REFRAC_EN
  localparam bit REFRAC_ON = 1'b1;
`else
  localparam bit REFRAC_ON = 1'b0;
`endif

  typedef logic [N-1:0][IW-1:0] cur_t;

  typedef struct {
    bit           clr_first;
    int           ch;
    int           cur;
    int           thr;
    int           ls;
    logic [N-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_if_encoder_if #(.N(N), .IN_WIDTH(IW), .POT_WIDTH(PW)) bus ();

  spike_if_encoder #(.N(N), .IN_WIDTH(IW), .POT_WIDTH(PW), .REFRAC(REFRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_v   [N];
  int           m_cnt [N];
  logic [N-1:0] m_out;
  bit           m_ov;
  vec_t         tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 0;
      m_cnt[i] = 0;
    end
  endfunction

  // Reference neuron layer in plain integer arithmetic
  function automatic logic [N-1:0] model_step(input cur_t cur, input int thr, input int ls);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      int nv;
      if (REFRAC_ON && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        m_v[i]   = 0;
      end else begin
        nv = m_v[i] - ((ls == 0) ? 0 : (m_v[i] / (1 << ls))) + int'(cur[i]);
        if (nv > VMAX) nv = VMAX;
        if (nv >= thr) begin
          s[i]     = 1'b1;
          m_v[i]   = 0;
          m_cnt[i] = REFRAC;
        end else begin
          m_v[i] = nv;
        end
      end
    end
    return s;
  endfunction

  function automatic cur_t one_hot_cur(input int ch, input int val);
    cur_t c;
    c = '0;
    c[ch] = IW'(val);
    return c;
  endfunction

  function automatic void add(input bit c, input int ch, input int cur, input int thr,
                              input int ls, input logic [N-1:0] e);
    vec_t v;
    v.clr_first = c;
    v.ch        = ch;
    v.cur       = cur;
    v.thr       = thr;
    v.ls        = ls;
    v.exp       = e;
    tbl.push_back(v);
  endfunction

  task automatic do_clr();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr       = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    model_clear();
    m_ov = 1'b0;
  endtask

  // One accepted timestep with out_ready high; returns observed spikes
  task automatic do_step(input cur_t cur, input int thr, input int ls, output logic [N-1:0] got);
    bus.currents   = cur;
    bus.threshold  = PW'(thr);
    bus.leak_shift = 4'(ls);
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    chk("step_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    m_out = model_step(cur, thr, ls);
    m_ov  = 1'b1;
    bus.in_valid = 1'b0;
    chk("step_out_valid", 64'(bus.out_valid), 64'd1);
    got = bus.spikes_out;
  endtask

  initial begin
    logic [N-1:0] got;
    bus.in_valid   = 1'b0;
    bus.currents   = '0;
    bus.threshold  = '0;
    bus.leak_shift = '0;
    bus.clr        = 1'b0;
    bus.out_ready  = 1'b0;
    model_clear();
    m_out = '0;
    m_ov  = 1'b0;

    #2;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_spikes", 64'(bus.spikes_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // integrate, leak, refractory, threshold zero
    add(1, 0, 40, 100, 0, 8'h00);
    add(0, 0, 40, 100, 0, 8'h00);
    add(0, 0, 40, 100, 0, 8'h01);
    add(0, 0, 40, 100, 0, 8'h00);
    add(1, 0, 64, 100, 1, 8'h00);
    add(0, 0, 64, 100, 1, 8'h00);
    add(0, 0, 64, 100, 1, 8'h01);
    for (int k = 0; k < 6; k++) begin
      add(k == 0, 3, 50, 10, 0, (REFRAC_ON && (k % 3) != 0) ? 8'h00 : 8'h08);
    end
    add(1, 0, 0, 0, 0, 8'hFF);
    add(0, 0, 0, 0, 0, REFRAC_ON ? 8'h00 : 8'hFF);

    for (int t = 0; t < tbl.size(); t++) begin
      if (tbl[t].clr_first) do_clr();
      do_step(one_hot_cur(tbl[t].ch, tbl[t].cur), tbl[t].thr, tbl[t].ls, got);
      chk($sformatf("table[%0d]", t), 64'(got), 64'(tbl[t].exp));
    end

    // saturation: 32 x 2047 = 65504, 33rd step saturates to 65535
    do_clr();
    for (int s = 1; s <= 33; s++) begin
      do_step(one_hot_cur(7, 2047), 16'hFFFF, 0, got);
      chk($sformatf("saturate[%0d]", s), 64'(got), (s == 33) ? 64'h80 : 64'h00);
    end

    // backpressure: stall three cycles, then simultaneous drain + accept
    do_clr();
    do_step(one_hot_cur(1, 500), 300, 0, got);
    chk("bp_first", 64'(got), 64'h02);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.currents  = one_hot_cur(2, 200);
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_spikes_stable", 64'(bus.spikes_out), 64'h02);
      chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    m_out = model_step(one_hot_cur(2, 200), 300, 0);
    bus.in_valid = 1'b0;
    chk("bp_swap_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_swap_spikes", 64'(bus.spikes_out), 64'h00);
    do_step(one_hot_cur(2, 150), 300, 0, got);
    chk("bp_single_accept", 64'(got), 64'h04);
    @(posedge clk); #1;
    m_ov = 1'b0;
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // clr with pending output and in_valid high
    do_clr();
    do_step(one_hot_cur(0, 60) | one_hot_cur(5, 500), 100, 0, got);
    chk("clr_pre", 64'(got), 64'h20);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.clr       = 1'b1;
    bus.currents  = one_hot_cur(0, 60);
    #1 chk("clr_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    chk("clr_pending_valid", 64'(bus.out_valid), 64'd1);
    chk("clr_pending_spikes", 64'(bus.spikes_out), 64'h20);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("clr_delivered", 64'(bus.out_valid), 64'd0);
    do_step(one_hot_cur(0, 60), 100, 0, got);
    chk("clr_potential_zero", 64'(got), 64'h00);

    // asynchronous reset while output pending
    do_step(one_hot_cur(4, 500), 100, 0, got);
    chk("rst_pre", 64'(got), 64'h10);
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_async_spikes", 64'(bus.spikes_out), 64'd0);
    #1 rst = 1'b0;
    model_clear();
    m_out = '0;
    m_ov  = 1'b0;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // random traffic with backpressure and occasional clr
    for (int k = 0; k < 400; k++) begin
      cur_t cur;
      int   thr;
      int   ls;
      bit   iv;
      bit   ordy;
      bit   cl;
      bit   exp_rdy;
      bit   acc;
      for (int i = 0; i < N; i++) cur[i] = IW'($urandom_range(0, 1000));
      thr  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3000));
      ls   = int'($urandom_range(0, 15));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cl   = ($urandom_range(0, 24) == 0);
      bus.currents   = cur;
      bus.threshold  = PW'(thr);
      bus.leak_shift = 4'(ls);
      bus.in_valid   = iv;
      bus.out_ready  = ordy;
      bus.clr        = cl;
      exp_rdy = !cl && (!m_ov || ordy);
      acc     = iv && exp_rdy;
      #1 chk("rand_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      @(posedge clk); #1;
      if (cl) begin
        model_clear();
        if (ordy) m_ov = 1'b0;
      end else if (acc) begin
        m_out = model_step(cur, thr, ls);
        m_ov  = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      chk("rand_out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("rand_spikes", 64'(bus.spikes_out), 64'(m_out));
    end
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_if_encoder.md
# spike_if_encoder

Layer of N integrate-and-fire neurons converting per-column weighted sums from a spike MAC back into a spike vector, closing the loop so one layer's output spikes drive the next MAC. Each accepted input vector is one timestep: currents are integrated into saturating membrane potentials with shift-based leak, compared against a threshold, and fire one spike bit per neuron. Input and output use valid/ready handshakes with a single-entry output register.

## Interface
- N, 8, number of neurons (MAC columns)
- IN_WIDTH, OUT_WIDTH (DPE_params.sv), width of each unsigned input current
- POT_WIDTH, 16, membrane potential width (≥ IN_WIDTH+1)
- REFRAC, 2, refractory timesteps after a spike (0–15)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  currents valid
- in_ready  out  1  block can accept currents
- currents  in  [N-1:0][IN_WIDTH-1:0]  unsigned column sums
- threshold  in  POT_WIDTH  firing threshold, sampled on accept
- leak_shift  in  4  leak = v >> leak_shift; 0 = no leak
- clr  in  1  synchronous clear of potentials and refractory counters
- out_valid  out  1  spikes_out holds an unconsumed timestep
- out_ready  in  1  consumer accepts spikes_out
- spikes_out  out  N  spike vector, bit i = neuron i

## Operation
- Accept when in_valid && in_ready; in_ready = !clr && (!out_valid || out_ready) (combinational).
- Per neuron i on accept:
  - refractory (cnt[i] != 0): cnt[i] -= 1, v[i] held at 0, spike 0; current discarded.
  - else v' = v − (leak_shift==0 ? 0 : v >> leak_shift) + current, computed in POT_WIDTH+1 bits, saturating to 2^POT_WIDTH−1.
  - v' ≥ threshold → spike 1, v[i] = 0, cnt[i] = REFRAC; otherwise spike 0, v[i] = v'.
- threshold = 0: every non-refractory neuron fires on every timestep.
- Output buffer FSM: EMPTY (out_valid=0) → FULL on accept. FULL → EMPTY on out_ready with no accept; FULL → FULL on simultaneous out_ready and accept (new vector loaded same edge).
- clr: v and cnt cleared to 0 at the edge; output register and out_valid untouched; no input accepted that cycle (clr wins over in_valid).
- Potentials, counters and spikes_out change only on accept, clr or rst.

## Timing
- Reset (async, immediate): spikes_out = 0, out_valid = 0, all v = 0, all cnt = 0; in_ready = 1 once rst deasserts (absent clr).
- Latency: spikes for a timestep appear with out_valid=1 the cycle after accept.
- Throughput: one timestep per cycle when out_ready held high.
- Backpressure: while out_valid && !out_ready, spikes_out stable, in_ready = 0, state frozen.
- rst mid-operation: pending output discarded, state cleared; no partial update.

## Configuration
- SPIKE_REFRAC_EN defined: refractory counters built; behaviour as above.
- Undefined: no counters, REFRAC ignored, neurons may fire on consecutive timesteps; potential still resets to 0 on spike.

## Test plan
- Integrate: threshold=100, leak_shift=0, REFRAC=0, currents[0]=40 for 3 timesteps -> spikes_out[0] = 0,0,1; next 40 -> 0 (v restarted at 0).
- Leak: threshold=100, leak_shift=1, currents[0]=64 each step -> v 64, 96, then 112 ≥ 100 -> spike on 3rd timestep.
- Refractory: REFRAC=2, threshold=10, currents[3]=50 each of 6 steps -> bit 3 = 1,0,0,1,0,0 with SPIKE_REFRAC_EN; 1,1,1,1,1,1 without.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, spikes_out unchanged, exactly one accept after out_ready rises; simultaneous out_ready+accept keeps out_valid=1 with new vector.
- Saturation: POT_WIDTH=16, threshold=0xFFFF, leak_shift=0, currents[7]=2047 -> no spike for 32 steps (v=65504), spike on 33rd (saturated 65535).
- Reset/clear: rst asserted while out_valid=1 -> out_valid and spikes_out 0 without clock edge; clr with in_valid=1 -> in_ready=0, potentials 0 next cycle, pending output still delivered.
